// File: rtl/uart_rx_port.sv
// uart_rx_port: UART receive stage (2-FF sync, fractional baud ticks,
// 3-sample majority vote, 8N1 or 8E1 framing, one-byte holding register).
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing, parity_err live).
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   rd_strobe  one-cycle pulse, CPU consumed data_out
//   data_out   received byte (LSB first on the line)
//   data_ready holding register full
//   frame_err  stop bit of current data_out sampled low
//   parity_err parity mismatch of current data_out (0 without the macro)
//   overrun    sticky, a byte was lost while data_ready was set
module uart_rx_port #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_strobe,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam longint INC_L =
        (longint'(BAUD) * OVERSAMPLE * 65536 * 2 + CLK_FREQ)
        / (2 * longint'(CLK_FREQ));
    localparam logic [16:0] INC = 17'(INC_L);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BRK    = 3'd5;

    logic          r_sync1, r_sync2;
    logic [16:0]   r_acc;
    logic [2:0]    r_state;
    logic [SW-1:0] r_scnt;
    logic [2:0]    r_bitcnt;
    logic          r_s_lo, r_s_mid;
    logic [7:0]    r_shreg;
    logic          r_load, r_ld_fe;
    logic [7:0]    r_data;
    logic          r_ready, r_fe, r_ovr;

    logic w_rxs, w_tick, w_vote, w_vote_t, w_wrap, w_ld_ok;

    assign w_rxs    = r_sync2;
    assign w_tick   = r_acc[16];
    assign w_vote_t = w_tick && (r_scnt == S_HI);
    assign w_wrap   = w_tick && (r_scnt == S_END);
    // third sample is the live rxs at the vote tick
    assign w_vote   = (r_s_lo & r_s_mid) | (r_s_lo & w_rxs) |
                      (r_s_mid & w_rxs);
    // a pending byte is accepted if the register is free or being read now
    assign w_ld_ok  = r_load && (!r_ready || rd_strobe);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // held at INC while idle so the first frame tick has a fixed phase
    always_ff @(posedge clk) begin
        if (reset)
            r_acc <= 17'd0;
        else if (r_state == IDLE)
            r_acc <= INC;
        else
            r_acc <= {1'b0, r_acc[15:0]} + INC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_scnt   <= '0;
            r_bitcnt <= 3'd0;
            r_s_lo   <= 1'b1;
            r_s_mid  <= 1'b1;
            r_shreg  <= 8'd0;
            r_load   <= 1'b0;
            r_ld_fe  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (w_tick && r_state != IDLE) begin
                r_scnt <= r_scnt + SW'(1);
                if (r_scnt == S_LO)
                    r_s_lo <= w_rxs;
                if (r_scnt == S_MID)
                    r_s_mid <= w_rxs;
            end
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state  <= START;
                        r_scnt   <= '0;
                        r_bitcnt <= 3'd0;
                    end
                end
                START: begin
                    if (w_vote_t && w_vote)
                        r_state <= IDLE;
                    else if (w_wrap)
                        r_state <= DATA;
                end
                DATA: begin
                    if (w_vote_t)
                        r_shreg <= {w_vote, r_shreg[7:1]};
                    if (w_wrap) begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_wrap)
                        r_state <= STOP;
                end
`endif
                STOP: begin
                    // decided mid stop bit so back-to-back frames fit
                    if (w_vote_t) begin
                        r_load  <= 1'b1;
                        r_ld_fe <= ~w_vote;
                        r_state <= w_vote ? IDLE : BRK;
                    end
                end
                BRK: begin
                    if (w_rxs)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= 8'd0;
            r_ready <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (r_load) begin
            if (w_ld_ok) begin
                r_data  <= r_shreg;
                r_ready <= 1'b1;
                r_fe    <= r_ld_fe;
                if (rd_strobe)
                    r_ovr <= 1'b0;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (rd_strobe) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_ld_pe, r_pe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_pe <= 1'b0;
            r_pe    <= 1'b0;
        end else begin
            if (r_state == PARITY && w_vote_t)
                r_ld_pe <= w_vote ^ (^r_shreg);
            if (w_ld_ok)
                r_pe <= r_ld_pe;
        end
    end

    assign parity_err = r_pe;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = r_data;
    assign data_ready = r_ready;
    assign frame_err  = r_fe;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: randomized self-checking bench for uart_rx_port.
// 1843200 Hz clock, 115200 baud, 16x oversampling -> 16 clk per bit.
module tb_uart_rx_port;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx        = 1'b1;
    logic       rd_strobe = 1'b0;
    logic [7:0] data_out;
    logic       data_ready, frame_err, parity_err, overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_ready, m_fe, m_pe, m_ovr;

    logic [11:0] dut_v;
    assign dut_v = {data_out, data_ready, frame_err, parity_err, overrun};

    uart_rx_port #(
        .CLK_FREQ  (1843200),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_strobe (rd_strobe),
        .data_out  (data_out),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // holding-register model: what the CPU should see after each event
    function automatic logic [11:0] m_vec();
        return {m_data, m_ready, m_fe, m_pe, m_ovr};
    endfunction

    function automatic void m_reset();
        m_data = 8'd0; m_ready = 0; m_fe = 0; m_pe = 0; m_ovr = 0;
    endfunction

    function automatic void m_deliver(input logic [7:0] d,
                                      input logic fe, input logic pe);
        if (!m_ready) begin
            m_data = d; m_ready = 1; m_fe = fe; m_pe = pe;
        end else begin
            m_ovr = 1;
        end
    endfunction

    function automatic void m_read();
        m_ready = 0; m_ovr = 0;
    endfunction

    function automatic logic exp_pe(input logic [7:0] d, input logic pb);
        return PAR ? (pb ^ (^d)) : 1'b0;
    endfunction

    // all driving happens 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input logic pb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(pb);
        drive_bit(stopb);
    endtask

    task automatic do_read();
        rd_strobe = 1'b1;
        idle(1);
        rd_strobe = 1'b0;
        m_read();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        m_reset();
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL reset: got %h exp %h", dut_v, m_vec());
        end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(4);
        m_deliver(8'hA5, 1'b0, 1'b0);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL basic_a5: got %h exp %h", dut_v, m_vec());
        end
        do_read();
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL basic_read: got %h exp %h", dut_v, m_vec());
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL glitch: got %h exp %h", dut_v, m_vec());
        end
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle(4);
        m_deliver(8'h3C, 1'b0, 1'b0);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL glitch_3c: got %h exp %h", dut_v, m_vec());
        end
        do_read();
    endtask

    task automatic test_break();
        send_frame(8'h55, 1'b0, ^8'h55);
        idle(40);
        m_deliver(8'h55, 1'b1, 1'b0);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL break_55: got %h exp %h", dut_v, m_vec());
        end
        do_read();
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL break_read: got %h exp %h", dut_v, m_vec());
        end
        idle(40);
        rx = 1'b1;
        idle(40);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL break_nostart: got %h exp %h", dut_v, m_vec());
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, ^8'h11);
        m_deliver(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22);
        m_deliver(8'h22, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL overrun: got %h exp %h", dut_v, m_vec());
        end
        do_read();
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL overrun_read: got %h exp %h", dut_v, m_vec());
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h5A, 1'b1, ^8'h5A);
        m_deliver(8'h5A, 1'b0, 1'b0);
        idle(3);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        idle(BIT / 2);
        reset = 1'b1;
        idle(2);
        m_reset();
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL reset_mid: got %h exp %h", dut_v, m_vec());
        end
        reset = 1'b0;
        idle(BIT / 2 - 2 + 3 * BIT + (PAR ? BIT : 0) + BIT + 8);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL reset_tail: got %h exp %h", dut_v, m_vec());
        end
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(4);
        m_deliver(8'h81, 1'b0, 1'b0);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL reset_81: got %h exp %h", dut_v, m_vec());
        end
        do_read();
    endtask

    // byte must appear inside the stop bit, not before it
    task automatic test_latency();
        logic [7:0] d;
        d = 8'($urandom);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(^d);
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: got %b exp 0", data_ready);
        end
        rx = 1'b1;
        idle(BIT - 1);
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_stop: got %b exp 1", data_ready);
        end
        idle(1);
        m_deliver(d, 1'b0, 1'b0);
        checks++;
        if (dut_v !== m_vec()) begin
            errors++;
            $display("FAIL lat_data: got %h exp %h", dut_v, m_vec());
        end
        do_read();
        idle(3);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stopb, pb;
        int         gap;
        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            stopb = ($urandom_range(0, 7) != 0);
            pb    = 1'($urandom);
            gap   = $urandom_range(0, 12);
            if (!stopb && gap < 2) gap = 2;
            send_frame(d, stopb, pb);
            m_deliver(d, !stopb, exp_pe(d, pb));
            checks++;
            if (dut_v !== m_vec()) begin
                errors++;
                $display("FAIL rand_%0d byte %h: got %h exp %h",
                         n, d, dut_v, m_vec());
            end
            rx = 1'b1;
            if (gap >= 3 && $urandom_range(0, 1) == 1) begin
                do_read();
                checks++;
                if (dut_v !== m_vec()) begin
                    errors++;
                    $display("FAIL rand_rd_%0d: got %h exp %h",
                             n, dut_v, m_vec());
                end
                idle(gap - 1);
            end else begin
                idle(gap);
            end
        end
        idle(10);
        if (m_ready) do_read();
        idle(3);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        for (int p = 1; p >= 0; p--) begin
            send_frame(8'h07, 1'b1, 1'(p));
            idle(4);
            m_deliver(8'h07, 1'b0, exp_pe(8'h07, 1'(p)));
            checks++;
            if (dut_v !== m_vec()) begin
                errors++;
                $display("FAIL parity_p%0d: got %h exp %h",
                         p, dut_v, m_vec());
            end
            do_read();
        end
    endtask
`endif

    initial begin
        idle(1);
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        test_latency();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
